// File: rtl/instr_decode_hs_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for instr_decode_hs.
// master = pipeline neighbours (fetch + execute), slave = the decode stage.
interface instr_decode_hs_if #(
  parameter int wd_instr_p = 32,
  parameter int wd_pc_p    = 32
);
  logic                  i_valid;
  logic                  o_ready;
  logic [wd_instr_p-1:0] i_instr;
  logic [wd_pc_p-1:0]    i_pc;
  logic                  o_valid;
  logic                  i_ready;

  modport master (
    output i_valid, i_instr, i_pc, i_ready,
    input  o_ready, o_valid
  );

  modport slave (
    input  i_valid, i_instr, i_pc, i_ready,
    output o_ready, o_valid
  );
endinterface

// File: rtl/instr_decode_hs.sv
// Handshaked RV32I decode stage with load-use bubble and flush.
// Optional macro DECODE_ILLEGAL_TRAP_EN: flag invalid encodings on o_illegal.
package arriskv_pkg;
  typedef enum logic [5:0] {
    OP_NOP = 6'd0,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_SB, OP_SH, OP_SW,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR
  } instruction_t;
endpackage

module instr_decode_hs
  import arriskv_pkg::*;
#(
  parameter int wd_instr_p  = 32,
  parameter int wd_regs_p   = 32,
  parameter int n_regs_p    = 32,
  parameter int wd_pc_p     = 32,
  localparam int wd_addr_p  = $clog2(n_regs_p)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_flush,
  instr_decode_hs_if.slave               bus,
  output logic [1:0][wd_addr_p-1:0]      o_reg_rd_addr,
  output instruction_t                   o_op,
  output logic [wd_addr_p-1:0]           o_rdest,
  output logic [wd_regs_p-1:0]           o_imm_se,
  output logic [wd_pc_p-1:0]             o_pc,
  output logic                           o_jump,
  output logic                           o_load,
  output logic                           o_store,
  output logic                           o_illegal
);

  logic [6:0]           w_opc;
  logic [2:0]           w_f3;
  logic [6:0]           w_f7;
  logic [wd_addr_p-1:0] w_rd;
  logic [wd_addr_p-1:0] w_rs1;
  logic [wd_addr_p-1:0] w_rs2;
  logic [31:0]          w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

  assign w_opc   = bus.i_instr[6:0];
  assign w_f3    = bus.i_instr[14:12];
  assign w_f7    = bus.i_instr[31:25];
  assign w_rd    = wd_addr_p'(bus.i_instr[11:7]);
  assign w_rs1   = wd_addr_p'(bus.i_instr[19:15]);
  assign w_rs2   = wd_addr_p'(bus.i_instr[24:20]);
  assign w_imm_i = {{20{bus.i_instr[31]}}, bus.i_instr[31:20]};
  assign w_imm_s = {{20{bus.i_instr[31]}}, bus.i_instr[31:25], bus.i_instr[11:7]};
  assign w_imm_b = {{19{bus.i_instr[31]}}, bus.i_instr[31], bus.i_instr[7],
                    bus.i_instr[30:25], bus.i_instr[11:8], 1'b0};
  assign w_imm_u = {bus.i_instr[31:12], 12'd0};
  assign w_imm_j = {{11{bus.i_instr[31]}}, bus.i_instr[31], bus.i_instr[19:12],
                    bus.i_instr[20], bus.i_instr[30:21], 1'b0};

  instruction_t         w_op_raw;
  logic [wd_addr_p-1:0] w_rdest_raw;
  logic [31:0]          w_imm_raw;
  logic                 w_jump_raw, w_load_raw, w_store_raw;
  logic                 w_bad;
  logic                 w_use_rs1, w_use_rs2;

  // Full opcode/funct decode of the incoming word, plus which rs fields it reads.
  always_comb begin
    w_op_raw    = OP_NOP;
    w_rdest_raw = w_rd;
    w_imm_raw   = 32'd0;
    w_jump_raw  = 1'b0;
    w_load_raw  = 1'b0;
    w_store_raw = 1'b0;
    w_bad       = 1'b0;
    w_use_rs1   = 1'b0;
    w_use_rs2   = 1'b0;
    case (w_opc)
      7'b0000011: begin
        w_use_rs1  = 1'b1;
        w_imm_raw  = w_imm_i;
        w_load_raw = 1'b1;
        case (w_f3)
          3'b000:  w_op_raw = OP_LB;
          3'b001:  w_op_raw = OP_LH;
          3'b010:  w_op_raw = OP_LW;
          3'b100:  w_op_raw = OP_LBU;
          3'b101:  w_op_raw = OP_LHU;
          default: w_bad    = 1'b1;
        endcase
      end
      7'b0010011: begin
        w_use_rs1 = 1'b1;
        w_imm_raw = w_imm_i;
        case (w_f3)
          3'b000: w_op_raw = OP_ADDI;
          3'b010: w_op_raw = OP_SLTI;
          3'b011: w_op_raw = OP_SLTIU;
          3'b100: w_op_raw = OP_XORI;
          3'b110: w_op_raw = OP_ORI;
          3'b111: w_op_raw = OP_ANDI;
          3'b001: begin
            if (w_f7 == 7'b0000000) w_op_raw = OP_SLLI;
            else                    w_bad    = 1'b1;
          end
          3'b101: begin
            if (w_f7 == 7'b0000000)      w_op_raw = OP_SRLI;
            else if (w_f7 == 7'b0100000) w_op_raw = OP_SRAI;
            else                         w_bad    = 1'b1;
          end
          default: w_bad = 1'b1;
        endcase
      end
      7'b0110011: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        if (w_f7 == 7'b0000000) begin
          case (w_f3)
            3'b000:  w_op_raw = OP_ADD;
            3'b001:  w_op_raw = OP_SLL;
            3'b010:  w_op_raw = OP_SLT;
            3'b011:  w_op_raw = OP_SLTU;
            3'b100:  w_op_raw = OP_XOR;
            3'b101:  w_op_raw = OP_SRL;
            3'b110:  w_op_raw = OP_OR;
            3'b111:  w_op_raw = OP_AND;
            default: w_bad    = 1'b1;
          endcase
        end else if (w_f7 == 7'b0100000) begin
          case (w_f3)
            3'b000:  w_op_raw = OP_SUB;
            3'b101:  w_op_raw = OP_SRA;
            default: w_bad    = 1'b1;
          endcase
        end else begin
          w_bad = 1'b1;
        end
      end
      7'b0100011: begin
        w_use_rs1   = 1'b1;
        w_use_rs2   = 1'b1;
        w_rdest_raw = '0;
        w_imm_raw   = w_imm_s;
        w_store_raw = 1'b1;
        case (w_f3)
          3'b000:  w_op_raw = OP_SB;
          3'b001:  w_op_raw = OP_SH;
          3'b010:  w_op_raw = OP_SW;
          default: w_bad    = 1'b1;
        endcase
      end
      7'b1100011: begin
        w_use_rs1   = 1'b1;
        w_use_rs2   = 1'b1;
        w_rdest_raw = '0;
        w_imm_raw   = w_imm_b;
        w_jump_raw  = 1'b1;
        case (w_f3)
          3'b000:  w_op_raw = OP_BEQ;
          3'b001:  w_op_raw = OP_BNE;
          3'b100:  w_op_raw = OP_BLT;
          3'b101:  w_op_raw = OP_BGE;
          3'b110:  w_op_raw = OP_BLTU;
          3'b111:  w_op_raw = OP_BGEU;
          default: w_bad    = 1'b1;
        endcase
      end
      7'b0110111: begin
        w_op_raw  = OP_LUI;
        w_imm_raw = w_imm_u;
      end
      7'b0010111: begin
        w_op_raw  = OP_AUIPC;
        w_imm_raw = w_imm_u;
      end
      7'b1101111: begin
        w_op_raw   = OP_JAL;
        w_imm_raw  = w_imm_j;
        w_jump_raw = 1'b1;
      end
      7'b1100111: begin
        w_use_rs1  = 1'b1;
        w_imm_raw  = w_imm_i;
        w_jump_raw = 1'b1;
        if (w_f3 == 3'b000) w_op_raw = OP_JALR;
        else                w_bad    = 1'b1;
      end
      default: w_bad = 1'b1;
    endcase
  end

  // Invalid encodings collapse to a NOP with no destination and no class flags.
  instruction_t         w_op;
  logic [wd_addr_p-1:0] w_rdest;
  logic [wd_regs_p-1:0] w_imm_se;
  logic                 w_jump, w_load, w_store, w_illegal;

  assign w_op     = w_bad ? OP_NOP : w_op_raw;
  assign w_rdest  = w_bad ? '0 : w_rdest_raw;
  assign w_imm_se = w_bad ? '0 : wd_regs_p'($signed(w_imm_raw));
  assign w_jump   = w_jump_raw  & ~w_bad;
  assign w_load   = w_load_raw  & ~w_bad;
  assign w_store  = w_store_raw & ~w_bad;

`ifdef DECODE_ILLEGAL_TRAP_EN
  assign w_illegal = w_bad;
`else
  assign w_illegal = 1'b0;
`endif

  logic                      r_valid;
  logic [1:0][wd_addr_p-1:0] r_reg_rd_addr;
  instruction_t              r_op;
  logic [wd_addr_p-1:0]      r_rdest;
  logic [wd_regs_p-1:0]      r_imm_se;
  logic [wd_pc_p-1:0]        r_pc;
  logic                      r_jump, r_load, r_store, r_illegal;

  logic w_hazard, w_ready, w_accept;

  assign w_hazard = r_valid & r_load & (r_rdest != '0) & bus.i_valid &
                    ((w_use_rs1 & (w_rs1 == r_rdest)) | (w_use_rs2 & (w_rs2 == r_rdest)));
  assign w_ready  = ~rst & ~i_flush & ~w_hazard & (~r_valid | bus.i_ready);
  assign w_accept = bus.i_valid & w_ready;

  // Single output register: reset/flush, accept, drain on execute ready, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid       <= 1'b0;
      r_reg_rd_addr <= '0;
      r_op          <= OP_NOP;
      r_rdest       <= '0;
      r_imm_se      <= '0;
      r_pc          <= '0;
      r_jump        <= 1'b0;
      r_load        <= 1'b0;
      r_store       <= 1'b0;
      r_illegal     <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid          <= 1'b1;
      r_reg_rd_addr[0] <= w_rs1;
      r_reg_rd_addr[1] <= w_rs2;
      r_op             <= w_op;
      r_rdest          <= w_rdest;
      r_imm_se         <= w_imm_se;
      r_pc             <= bus.i_pc;
      r_jump           <= w_jump;
      r_load           <= w_load;
      r_store          <= w_store;
      r_illegal        <= w_illegal;
    end else if (bus.i_ready) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign bus.o_ready   = w_ready;
  assign bus.o_valid   = r_valid;
  assign o_reg_rd_addr = r_reg_rd_addr;
  assign o_op          = r_op;
  assign o_rdest       = r_rdest;
  assign o_imm_se      = r_imm_se;
  assign o_pc          = r_pc;
  assign o_jump        = r_jump;
  assign o_load        = r_load;
  assign o_store       = r_store;
  assign o_illegal     = r_illegal;

endmodule

// File: tb/tb_instr_decode_hs.sv
// Directed, table-driven bench for instr_decode_hs (32-bit and 64-bit register widths).
module tb_instr_decode_hs;
  import arriskv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic flush;

  instr_decode_hs_if bus();
  instr_decode_hs_if bus64();

  logic [1:0][4:0] rd_addr, rd_addr64;
  instruction_t    op, op64;
  logic [4:0]      rdest, rdest64;
  logic [31:0]     imm;
  logic [63:0]     imm64;
  logic [31:0]     pc, pc64;
  logic            jump, load, store, illegal;
  logic            jump64, load64, store64, illegal64;

  instr_decode_hs dut (
    .clk(clk), .rst(rst), .i_flush(flush), .bus(bus),
    .o_reg_rd_addr(rd_addr), .o_op(op), .o_rdest(rdest), .o_imm_se(imm), .o_pc(pc),
    .o_jump(jump), .o_load(load), .o_store(store), .o_illegal(illegal)
  );

  instr_decode_hs #(.wd_regs_p(64)) dut64 (
    .clk(clk), .rst(rst), .i_flush(flush), .bus(bus64),
    .o_reg_rd_addr(rd_addr64), .o_op(op64), .o_rdest(rdest64), .o_imm_se(imm64), .o_pc(pc64),
    .o_jump(jump64), .o_load(load64), .o_store(store64), .o_illegal(illegal64)
  );

  assign bus64.i_valid = bus.i_valid;
  assign bus64.i_instr = bus.i_instr;
  assign bus64.i_pc    = bus.i_pc;
  assign bus64.i_ready = bus.i_ready;

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam logic ill_en = 1'b1;
`else
  localparam logic ill_en = 1'b0;
`endif

  typedef struct {
    logic [31:0]  instr;
    instruction_t op;
    logic [4:0]   rd;
    logic [31:0]  imm;
    logic [2:0]   jls;   // {jump, load, store}
    logic         bad;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
  } vec_t;

  localparam int n_vec = 15;
  vec_t vt [n_vec];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] act_pack();
    return {o_valid_w(), op, rdest, imm, pc, jump, load, store, illegal, rd_addr[0], rd_addr[1]};
  endfunction

  function automatic logic o_valid_w();
    return bus.o_valid;
  endfunction

  function automatic logic [127:0] exp_pack(input vec_t v, input logic [31:0] p);
    return {1'b1, v.op, v.rd, v.imm, p, v.jls, v.bad & ill_en, v.rs1, v.rs2};
  endfunction

  task automatic drive(input logic vld, input logic [31:0] ins, input logic [31:0] p);
    bus.i_valid = vld;
    bus.i_instr = ins;
    bus.i_pc    = p;
  endtask

  vec_t v_lui_nodep;

  initial begin
    vt[0]  = '{32'hFFF00093, OP_ADDI,  5'd1, 32'hFFFFFFFF, 3'b000, 1'b0, 5'd0,  5'd31};
    vt[1]  = '{32'h00012283, OP_LW,    5'd5, 32'h00000000, 3'b010, 1'b0, 5'd2,  5'd0};
    vt[2]  = '{32'h00001097, OP_AUIPC, 5'd1, 32'h00001000, 3'b000, 1'b0, 5'd0,  5'd0};
    vt[3]  = '{32'h00128333, OP_ADD,   5'd6, 32'h00000000, 3'b000, 1'b0, 5'd5,  5'd1};
    vt[4]  = '{32'h4041D193, OP_SRAI,  5'd3, 32'h00000404, 3'b000, 1'b0, 5'd3,  5'd4};
    vt[5]  = '{32'h00512423, OP_SW,    5'd0, 32'h00000008, 3'b001, 1'b0, 5'd2,  5'd5};
    vt[6]  = '{32'hFE208EE3, OP_BEQ,   5'd0, 32'hFFFFFFFC, 3'b100, 1'b0, 5'd1,  5'd2};
    vt[7]  = '{32'h001000EF, OP_JAL,   5'd1, 32'h00000800, 3'b100, 1'b0, 5'd0,  5'd1};
    vt[8]  = '{32'h800003B7, OP_LUI,   5'd7, 32'h80000000, 3'b000, 1'b0, 5'd0,  5'd0};
    vt[9]  = '{32'h00008067, OP_JALR,  5'd0, 32'h00000000, 3'b100, 1'b0, 5'd1,  5'd0};
    vt[10] = '{32'h402081B3, OP_SUB,   5'd3, 32'h00000000, 3'b000, 1'b0, 5'd1,  5'd2};
    vt[11] = '{32'h00109093, OP_SLLI,  5'd1, 32'h00000001, 3'b000, 1'b0, 5'd1,  5'd1};
    vt[12] = '{32'h40109093, OP_NOP,   5'd0, 32'h00000000, 3'b000, 1'b1, 5'd1,  5'd1};
    vt[13] = '{32'h00013283, OP_NOP,   5'd0, 32'h00000000, 3'b000, 1'b1, 5'd2,  5'd0};
    vt[14] = '{32'hFFFFFFFF, OP_NOP,   5'd0, 32'h00000000, 3'b000, 1'b1, 5'd31, 5'd31};
    v_lui_nodep = '{32'h000280B7, OP_LUI, 5'd1, 32'h00028000, 3'b000, 1'b0, 5'd5, 5'd0};

    rst = 1'b1;
    flush = 1'b0;
    bus.i_ready = 1'b1;
    drive(1'b1, vt[0].instr, 32'h0000_0010);
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", act_pack(), 128'd0);
    chk("reset_ready", {127'd0, bus.o_ready}, 128'd0);
    rst = 1'b0;
    drive(1'b0, 32'd0, 32'd0);

    // Back-to-back stream: vector i enters while vector i-1 is held.
    for (int i = 0; i <= n_vec; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("vec%0d", i - 1), act_pack(), exp_pack(vt[i - 1], 32'h1000 + 32'(4 * (i - 1))));
        chk($sformatf("vec%0d_imm64", i - 1), {64'd0, imm64}, {64'd0, {{32{vt[i - 1].imm[31]}}, vt[i - 1].imm}});
      end
      if (i < n_vec) begin
        drive(1'b1, vt[i].instr, 32'h1000 + 32'(4 * i));
        #1;
        chk($sformatf("vec%0d_ready", i), {127'd0, bus.o_ready}, 128'd1);
      end else begin
        drive(1'b0, 32'd0, 32'd0);
      end
    end

    // Load-use: LW x5 then ADD x6,x5,x1 -> one bubble.
    @(negedge clk);
    drive(1'b1, vt[1].instr, 32'h200);
    @(negedge clk);
    chk("lu_load_out", act_pack(), exp_pack(vt[1], 32'h200));
    drive(1'b1, vt[3].instr, 32'h204);
    #1;
    chk("lu_ready_low", {127'd0, bus.o_ready}, 128'd0);
    @(negedge clk);
    chk("lu_bubble", {127'd0, bus.o_valid}, 128'd0);
    chk("lu_ready_back", {127'd0, bus.o_ready}, 128'd1);
    @(negedge clk);
    chk("lu_dep_out", act_pack(), exp_pack(vt[3], 32'h204));

    // Load followed by an instruction whose unused rs1 field matches: no stall.
    drive(1'b1, vt[1].instr, 32'h210);
    @(negedge clk);
    drive(1'b1, v_lui_nodep.instr, 32'h214);
    #1;
    chk("lu_unused_rs_ready", {127'd0, bus.o_ready}, 128'd1);
    @(negedge clk);
    chk("lu_unused_rs_out", act_pack(), exp_pack(v_lui_nodep, 32'h214));

    // Backpressure: execute stalls 5 cycles while fetch keeps offering SUB.
    drive(1'b1, vt[0].instr, 32'h300);
    @(negedge clk);
    chk("stall_first", act_pack(), exp_pack(vt[0], 32'h300));
    bus.i_ready = 1'b0;
    drive(1'b1, vt[10].instr, 32'h304);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("stall_ready_%0d", k), {127'd0, bus.o_ready}, 128'd0);
      @(negedge clk);
      chk($sformatf("stall_hold_%0d", k), act_pack(), exp_pack(vt[0], 32'h300));
    end
    bus.i_ready = 1'b1;
    #1;
    chk("stall_release_ready", {127'd0, bus.o_ready}, 128'd1);
    @(negedge clk);
    chk("stall_next", act_pack(), exp_pack(vt[10], 32'h304));
    drive(1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("stall_no_dup", {127'd0, bus.o_valid}, 128'd0);

    // Flush with a held instruction and a concurrent offer.
    bus.i_ready = 1'b0;
    drive(1'b1, vt[10].instr, 32'h400);
    @(negedge clk);
    chk("flush_pre", act_pack(), exp_pack(vt[10], 32'h400));
    drive(1'b1, vt[0].instr, 32'h404);
    flush = 1'b1;
    #1;
    chk("flush_ready", {127'd0, bus.o_ready}, 128'd0);
    @(negedge clk);
    chk("flush_valid", {127'd0, bus.o_valid}, 128'd0);
    flush = 1'b0;
    #1;
    chk("flush_after_ready", {127'd0, bus.o_ready}, 128'd1);
    @(negedge clk);
    chk("flush_after_out", act_pack(), exp_pack(vt[0], 32'h404));

    // Reset mid-stream with a held instruction.
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_outputs", act_pack(), 128'd0);
    chk("midreset_ready", {127'd0, bus.o_ready}, 128'd0);
    rst = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    bus.i_ready = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
